// File: rtl/lap_stopwatch_bcd_pkg.sv
// stopwatch_pkg: types and constants shared by the lap stopwatch core,
// its lap FIFO and its lap pop-port interface.
//   bcd_time_t : packed M:SS.t time, {min, sec_tens, sec_units, tenths}
//   sw_mode_e  : count direction
//   sw_state_e : run/stop control state (also brought out for debug)
package stopwatch_pkg;

    localparam logic [3:0] DIGIT_MAX = 4'd9;  // tenths and seconds units
    localparam logic [3:0] TENS_MAX  = 4'd5;  // seconds tens

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] sec_tens;
        logic [3:0] sec_units;
        logic [3:0] tenths;
    } bcd_time_t;

    typedef enum logic {
        SW_UP   = 1'b0,
        SW_DOWN = 1'b1
    } sw_mode_e;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } sw_state_e;

    function automatic logic [3:0] sat_digit(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // Clamp every field of a raw BCD word into its legal range.
    function automatic bcd_time_t sat_time(input logic [15:0] raw, input logic [3:0] max_min);
        bcd_time_t t;
        t           = raw;
        t.min       = sat_digit(t.min, max_min);
        t.sec_tens  = sat_digit(t.sec_tens, TENS_MAX);
        t.sec_units = sat_digit(t.sec_units, DIGIT_MAX);
        t.tenths    = sat_digit(t.tenths, DIGIT_MAX);
        return t;
    endfunction

endpackage

// File: rtl/lap_stopwatch_bcd_if.sv
// Lap pop port of the stopwatch.
//   lap_valid : FIFO non-empty, lap_time holds the head entry
//   lap_ready : consumer accepts the head entry
//   lap_time  : head lap entry (BCD)
// Handshake: an entry is popped on every rising clock edge where
// lap_valid && lap_ready; while lap_valid && !lap_ready, lap_time is held
// stable; lap_valid never drops without a pop (or a clear/reset).
interface lap_stopwatch_bcd_if;
    import stopwatch_pkg::*;

    logic      lap_valid;
    logic      lap_ready;
    bcd_time_t lap_time;

    modport master (output lap_valid, output lap_time, input lap_ready);
    modport slave  (input lap_valid, input lap_time, output lap_ready);

endinterface

// File: rtl/lap_stopwatch_bcd_lap_fifo.sv
// lap_fifo: synchronous FIFO of bcd_time_t entries.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : empties the FIFO (wins over push/pop)
//   i_push/i_data  : write request and data; a push when full is dropped
//                    unless a pop happens in the same cycle
//   i_pop          : read request, ignored when empty
//   o_data         : head entry, zero when empty
//   o_full/o_empty : status
module lap_fifo
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_flush,
    input  logic      i_push,
    input  bcd_time_t i_data,
    input  logic      i_pop,
    output bcd_time_t o_data,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("lap_fifo: DEPTH must be a power of 2 and at least 2");
    end

    bcd_time_t   r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/lap_stopwatch_bcd.sv
// lap_stopwatch_bcd: stopwatch core with prescaler, M:SS.t BCD up/down
// counter, preload and a lap-capture FIFO.
//   clk_100MHz, reset_n : clock, asynchronous active-low reset
//   start/stop/clear    : single-cycle control pulses (clear > stop > load > start)
//   lap                 : push current time into the lap FIFO
//   load, load_time     : preload (saturated per field) while stopped
//   count_down          : direction, taken only while stopped
//   digit0..digit3      : tenths, sec units, sec tens, minutes
//   running             : counting active
//   tick/wrap/done      : one-cycle pulses on update / up rollover / down reaching zero
//   lap_overflow        : sticky, a lap was dropped because the FIFO was full
//   dbg_state           : run/stop control state
//   lap_if              : lap pop port (valid/ready)
module lap_stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 10,
    parameter int MAX_MIN   = 9,
    parameter int LAP_DEPTH = 4
) (
    input  logic                       clk_100MHz,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       clear,
    input  logic                       lap,
    input  logic                       load,
    input  logic [15:0]                load_time,
    input  logic                       count_down,
    output logic [3:0]                 digit0,
    output logic [3:0]                 digit1,
    output logic [3:0]                 digit2,
    output logic [3:0]                 digit3,
    output logic                       running,
    output logic                       tick,
    output logic                       wrap,
    output logic                       done,
    output logic                       lap_overflow,
    output sw_state_e                  dbg_state,
    lap_stopwatch_bcd_if.master        lap_if
);

    localparam int         DIV      = CLK_HZ / TICK_HZ;
    localparam int         PW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [3:0] MIN_MAX  = 4'(MAX_MIN);

    if (DIV < 2) begin : g_bad_div
        $error("lap_stopwatch_bcd: CLK_HZ/TICK_HZ must be at least 2");
    end
    if ((MAX_MIN < 1) || (MAX_MIN > 9)) begin : g_bad_min
        $error("lap_stopwatch_bcd: MAX_MIN must be 1..9");
    end

    sw_state_e     r_state;
    sw_state_e     w_state_nxt;
    sw_mode_e      r_mode;
    logic [PW-1:0] r_presc;
    bcd_time_t     r_time;
    bcd_time_t     w_time_up;
    bcd_time_t     w_time_dn;
    bcd_time_t     w_time_nxt;
    bcd_time_t     w_load_sat;
    bcd_time_t     w_fifo_data;
    logic          r_tick;
    logic          r_wrap;
    logic          r_done;
    logic          r_overflow;
    logic          w_running;
    logic          w_tick_now;
    logic          w_advance;
    logic          w_down_eff;
    logic          w_start_ok;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_fifo_full;
    logic          w_fifo_empty;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) r_state <= ST_STOPPED;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STOPPED: begin
                if (!clear && !stop && !load && w_start_ok) w_state_nxt = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (clear || stop) begin
                    w_state_nxt = ST_STOPPED;
                end else if (w_advance && (r_mode == SW_DOWN) && (w_time_dn == '0)) begin
                    // Down-count halts on the same edge that reaches zero.
                    w_state_nxt = ST_STOPPED;
                end
            end
            default: w_state_nxt = ST_STOPPED;
        endcase
    end

    always_comb begin
        w_running = (r_state == ST_RUNNING);
        dbg_state = r_state;
    end

    // While stopped the mode register tracks count_down every cycle, so the
    // live input is what the run will use; a down start at zero is refused.
    assign w_down_eff = w_running ? (r_mode == SW_DOWN) : count_down;
    assign w_start_ok = start && !(w_down_eff && (r_time == '0));

    // ---------------- prescaler / tick ----------------
    assign w_tick_now = w_running && (r_presc == PRE_LAST);
    // A stop or clear on the terminal prescaler cycle halts without updating.
    assign w_advance  = w_tick_now && !clear && !stop;

    // ---------------- BCD cascade ----------------
    always_comb begin
        w_time_up = r_time;
        if (r_time.tenths != DIGIT_MAX) begin
            w_time_up.tenths = r_time.tenths + 4'd1;
        end else begin
            w_time_up.tenths = '0;
            if (r_time.sec_units != DIGIT_MAX) begin
                w_time_up.sec_units = r_time.sec_units + 4'd1;
            end else begin
                w_time_up.sec_units = '0;
                if (r_time.sec_tens != TENS_MAX) begin
                    w_time_up.sec_tens = r_time.sec_tens + 4'd1;
                end else begin
                    w_time_up.sec_tens = '0;
                    w_time_up.min      = (r_time.min != MIN_MAX) ? r_time.min + 4'd1 : 4'd0;
                end
            end
        end
    end

    always_comb begin
        w_time_dn = r_time;
        if (r_time.tenths != 4'd0) begin
            w_time_dn.tenths = r_time.tenths - 4'd1;
        end else begin
            w_time_dn.tenths = DIGIT_MAX;
            if (r_time.sec_units != 4'd0) begin
                w_time_dn.sec_units = r_time.sec_units - 4'd1;
            end else begin
                w_time_dn.sec_units = DIGIT_MAX;
                if (r_time.sec_tens != 4'd0) begin
                    w_time_dn.sec_tens = r_time.sec_tens - 4'd1;
                end else begin
                    w_time_dn.sec_tens = TENS_MAX;
                    w_time_dn.min      = (r_time.min != 4'd0) ? r_time.min - 4'd1 : MIN_MAX;
                end
            end
        end
    end

    assign w_time_nxt = (r_mode == SW_DOWN) ? w_time_dn : w_time_up;
    assign w_load_sat = sat_time(load_time, MIN_MAX);

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_mode     <= SW_UP;
            r_presc    <= '0;
            r_time     <= '0;
            r_tick     <= 1'b0;
            r_wrap     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_tick <= w_advance;
            // Up-count only returns to zero from the maximum, so a zero
            // successor marks the rollover.
            r_wrap <= w_advance && (r_mode == SW_UP) && (w_time_up == '0);
            r_done <= w_advance && (r_mode == SW_DOWN) && (w_time_dn == '0);

            if (!w_running) r_mode <= count_down ? SW_DOWN : SW_UP;

            if (clear || stop || !w_running || w_tick_now) r_presc <= '0;
            else                                          r_presc <= r_presc + 1'b1;

            if (clear)                               r_time <= '0;
            else if (w_advance)                      r_time <= w_time_nxt;
            else if (!w_running && load && !stop)    r_time <= w_load_sat;

            if (clear)       r_overflow <= 1'b0;
            else if (w_drop) r_overflow <= 1'b1;
        end
    end

    // ---------------- lap FIFO ----------------
    assign w_push = lap && !clear;
    assign w_pop  = !w_fifo_empty && lap_if.lap_ready;
    assign w_drop = w_push && w_fifo_full && !w_pop;

    lap_fifo #(
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .i_clk   (clk_100MHz),
        .i_rst_n (reset_n),
        .i_flush (clear),
        .i_push  (w_push),
        .i_data  (r_time),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign lap_if.lap_valid = !w_fifo_empty;
    assign lap_if.lap_time  = w_fifo_data;

    // ---------------- outputs ----------------
    assign digit0       = r_time.tenths;
    assign digit1       = r_time.sec_units;
    assign digit2       = r_time.sec_tens;
    assign digit3       = r_time.min;
    assign running      = w_running;
    assign tick         = r_tick;
    assign wrap         = r_wrap;
    assign done         = r_done;
    assign lap_overflow = r_overflow;

endmodule
